// File: rtl/io_line_sequencer.sv
// -----------------------------------------------------------------------------
// io_line_sequencer
//
// Steps a bank of CHANNELS output-line controllers through a programmable
// table of {delay, duration} values. Each step is loaded onto the line buses,
// the lines are armed (mark) and fired (go), and the sequencer waits until
// every line reports completion before moving on. The whole table of
// num_steps steps is repeated repeat_count times.
//
// Optional feature macro: IO_SEQ_TIMEOUT_EN
//   When defined, a per-step watchdog aborts the sequence once a step has
//   spent TIMEOUT_CYCLES cycles in RUN, exactly as a hard_stop would.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   cfg_we            table write strobe (ignored while busy)
//   cfg_step/cfg_chan table address
//   cfg_delay/cfg_duration  table write data
//   num_steps         steps per pass, sampled at start, clamped to STEPS
//   repeat_count      passes, sampled at start, 0 treated as 1
//   start             begin a sequence (honoured only when idle)
//   hard_stop         abort immediately, highest priority
//   line_complete     per-channel completion flags from the line controllers
//   line_delay        per-channel delay,    channel c at [32c+31:32c]
//   line_duration     per-channel duration, same packing
//   line_mark         arm all lines
//   line_go           fire all lines
//   line_clr          active-high clear to all lines
//   busy              sequence in progress
//   done              one-cycle pulse on normal completion
//   aborted           one-cycle pulse on hard stop / timeout while busy
//   cur_step          step currently executing
//   cur_pass          zero-based pass index
// -----------------------------------------------------------------------------
module io_line_sequencer #(
  parameter int          CHANNELS       = 4,
  parameter int          STEPS          = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_we,
  input  logic [$clog2(STEPS)-1:0]   cfg_step,
  input  logic [$clog2(CHANNELS)-1:0] cfg_chan,
  input  logic [31:0]                cfg_delay,
  input  logic [31:0]                cfg_duration,
  input  logic [$clog2(STEPS):0]     num_steps,
  input  logic [15:0]                repeat_count,
  input  logic                       start,
  input  logic                       hard_stop,
  input  logic [CHANNELS-1:0]        line_complete,
  output logic [CHANNELS*32-1:0]     line_delay,
  output logic [CHANNELS*32-1:0]     line_duration,
  output logic                       line_mark,
  output logic                       line_go,
  output logic                       line_clr,
  output logic                       busy,
  output logic                       done,
  output logic                       aborted,
  output logic [$clog2(STEPS)-1:0]   cur_step,
  output logic [15:0]                cur_pass
);

  localparam int SW = $clog2(STEPS);

  localparam logic [SW:0] STEP_MAX = (SW+1)'(STEPS);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_ARM  = 3'd2;
  localparam logic [2:0] ST_RUN  = 3'd3;
  localparam logic [2:0] ST_NEXT = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic [SW:0] steps_q;
  logic [15:0] reps_q;
  logic        stop_clr_q;
  logic        aborted_q;

  logic [SW-1:0] step_d;
  logic [15:0]   pass_d;
  logic          load_en;
  logic          accept;
  logic          stop;
  logic          timeout_hit;
  logic          busy_w;

  logic [31:0] delay_tab [STEPS][CHANNELS];
  logic [31:0] dur_tab   [STEPS][CHANNELS];

  assign busy_w = (state_q == ST_LOAD) || (state_q == ST_ARM) ||
                  (state_q == ST_RUN)  || (state_q == ST_NEXT);

  // ---------------------------------------------------------------------------
  // Step table. Written only while idle so a running sequence always sees a
  // consistent table.
  // NOTE: the table is deliberately left out of reset; a reset mid-run must
  // not lose the programmed sequence, and a resettable array would also stop
  // this mapping onto plain storage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (cfg_we && !busy_w && (32'(cfg_step) < STEPS) && (32'(cfg_chan) < CHANNELS)) begin
      delay_tab[cfg_step][cfg_chan] <= cfg_delay;
      dur_tab[cfg_step][cfg_chan]   <= cfg_duration;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional per-step watchdog. The counter sits at zero outside RUN, so it
  // reads zero in the first RUN cycle and the abort lands exactly
  // TIMEOUT_CYCLES cycles after entering RUN.
  // ---------------------------------------------------------------------------
`ifdef IO_SEQ_TIMEOUT_EN
  logic [31:0] run_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      run_cnt_q <= '0;
    end else if (state_q != ST_RUN) begin
      run_cnt_q <= '0;
    end else begin
      run_cnt_q <= run_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = (state_q == ST_RUN) && (run_cnt_q == TIMEOUT_CYCLES - 32'd1);
`else
  assign timeout_hit = 1'b0;
`endif

  assign stop = hard_stop || timeout_hit;

  // ---------------------------------------------------------------------------
  // Next-state logic. step_d is also the table row loaded on the buses
  // whenever load_en is set (every transition into LOAD).
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    step_d  = cur_step;
    pass_d  = cur_pass;
    load_en = 1'b0;
    accept  = 1'b0;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (num_steps == '0) begin
              state_d = ST_DONE;
            end else begin
              accept  = 1'b1;
              load_en = 1'b1;
              step_d  = '0;
              pass_d  = '0;
              state_d = ST_LOAD;
            end
          end
        end
        ST_LOAD: state_d = ST_ARM;
        ST_ARM:  state_d = ST_RUN;
        ST_RUN: begin
          if (&line_complete) begin
            state_d = ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (({1'b0, cur_step} + (SW+1)'(1)) < steps_q) begin
            step_d  = cur_step + SW'(1);
            load_en = 1'b1;
            state_d = ST_LOAD;
          end else if (({1'b0, cur_pass} + 17'd1) < {1'b0, reps_q}) begin
            step_d  = '0;
            pass_d  = cur_pass + 16'd1;
            load_en = 1'b1;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers.
  // NOTE: non-blocking assignments throughout, so every register samples the
  // pre-edge values regardless of statement order.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      steps_q       <= '0;
      reps_q        <= '0;
      cur_step      <= '0;
      cur_pass      <= '0;
      stop_clr_q    <= 1'b0;
      aborted_q     <= 1'b0;
      line_delay    <= '0;
      line_duration <= '0;
    end else begin
      state_q    <= state_d;
      cur_step   <= step_d;
      cur_pass   <= pass_d;
      stop_clr_q <= stop;
      aborted_q  <= stop && busy_w;
      if (accept) begin
        steps_q <= (num_steps > STEP_MAX) ? STEP_MAX : num_steps;
        reps_q  <= (repeat_count == 16'd0) ? 16'd1 : repeat_count;
      end
      if (load_en) begin
        for (int c = 0; c < CHANNELS; c++) begin
          line_delay[32*c +: 32]    <= delay_tab[step_d][c];
          line_duration[32*c +: 32] <= dur_tab[step_d][c];
        end
      end
    end
  end

  // Control outputs decode directly from the state; the post-abort clear
  // comes from a one-cycle flag since the state is already back in IDLE.
  assign line_mark = (state_q == ST_ARM) || (state_q == ST_RUN);
  assign line_go   = (state_q == ST_RUN);
  assign line_clr  = (state_q == ST_LOAD) || (state_q == ST_NEXT) || stop_clr_q;
  assign busy      = busy_w;
  assign done      = (state_q == ST_DONE);
  assign aborted   = aborted_q;

endmodule

// File: doc/io_line_sequencer.md
# io_line_sequencer

Step sequencer for a bank of `CHANNELS` output-line controllers. It holds a programmable table of per-channel delay and duration values for up to `STEPS` steps. On `start` it loads each step into the line controllers, arms them, fires them, and waits for every channel to report completion. It then advances to the next step and repeats the whole table `repeat_count` times. It sits between the host register interface and the output-line controllers, and owns their mark, go and clear signals.

## Interface
Parameters:
- `CHANNELS`, default 4: number of output-line controllers driven.
- `STEPS`, default 8: depth of the step table.
- `TIMEOUT_CYCLES`, default 32'd100_000_000: per-step watchdog limit; used only with `IO_SEQ_TIMEOUT_EN`.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-low.
- `cfg_we`, in, 1: table write strobe; ignored while `busy`.
- `cfg_step`, in, `$clog2(STEPS)`: table step address.
- `cfg_chan`, in, `$clog2(CHANNELS)`: table channel address.
- `cfg_delay`, in, 32: delay value written.
- `cfg_duration`, in, 32: duration value written.
- `num_steps`, in, `$clog2(STEPS)+1`: steps per pass, sampled at `start`; clamped to `STEPS`.
- `repeat_count`, in, 16: passes, sampled at `start`; 0 is treated as 1.
- `start`, in, 1: begin sequence; honoured only in IDLE.
- `hard_stop`, in, 1: abort immediately.
- `line_complete`, in, `CHANNELS`: completion flags from the line controllers.
- `line_delay`, out, `CHANNELS*32`: per-channel delay; channel c occupies bits [32c+31:32c].
- `line_duration`, out, `CHANNELS*32`: per-channel duration, same packing.
- `line_mark`, out, 1: arm (onYourMark) to all lines.
- `line_go`, out, 1: fire to all lines.
- `line_clr`, out, 1: active-high clear to all lines.
- `busy`, out, 1: sequence in progress.
- `done`, out, 1: one-cycle pulse on normal completion.
- `aborted`, out, 1: one-cycle pulse on hard stop or timeout.
- `cur_step`, out, `$clog2(STEPS)`: step currently executing.
- `cur_pass`, out, 16: pass index, zero-based.

## Operation
- Table: `STEPS` x `CHANNELS` entries of {delay, duration} held in registers. Contents are not cleared by `rst`.
- FSM states: IDLE, LOAD, ARM, RUN, NEXT, DONE.
- **IDLE:**
  - `start` with `num_steps` != 0: latch the clamped step count and repeat count, set `cur_step`=0 and `cur_pass`=0, go to LOAD.
  - `start` with `num_steps`=0: pulse `done` directly; no other action.
- **LOAD:** drive `line_delay` and `line_duration` from table[`cur_step`], assert `line_clr`, go to ARM.
- **ARM:** `line_mark`=1, `line_go`=0, go to RUN.
- **RUN:** `line_mark`=1 and `line_go`=1. Stay in RUN until `line_complete` is all ones, then go to NEXT.
- **NEXT:** drop `line_mark` and `line_go`, assert `line_clr`, then:
  - If `cur_step`+1 < steps: increment `cur_step`, go to LOAD.
  - Else if `cur_pass`+1 < repeats: increment `cur_pass`, set `cur_step`=0, go to LOAD.
  - Else go to DONE.
- **DONE:** pulse `done`, go to IDLE.
- `line_delay` and `line_duration` stay stable from LOAD through NEXT.
- `hard_stop`, from any state, takes priority over `start` and all transitions:
  - Next cycle: state becomes IDLE, `line_mark`=`line_go`=0, `line_clr`=1 for one cycle.
  - `aborted` pulses only if the block was `busy`.
- `rst` low: state IDLE; all control outputs 0; `cur_step`, `cur_pass` and the line buses 0.

## Timing
- Reset values: `busy`, `done`, `aborted`, `line_mark`, `line_go` and `line_clr` are 0; `cur_step`, `cur_pass`, `line_delay` and `line_duration` are 0.
- Start latency: `start` sampled at edge 0. LOAD occupies cycle 1 and ARM cycle 2. `line_go` first asserts in cycle 3.
- `busy` rises the cycle after `start` and falls in the cycle `done` or `aborted` pulses.
- Step gap: 3 cycles (NEXT, LOAD, ARM) between `line_complete` all ones and the next `line_go`.
- `line_complete` is ignored outside RUN.
- A channel with delay 0 and duration 0 completes in one cycle; a step with all entries 0 lasts 4 cycles.

## Configuration
- `IO_SEQ_TIMEOUT_EN` defined:
  - A 32-bit counter clears on entry to RUN and increments each RUN cycle.
  - On reaching `TIMEOUT_CYCLES`, behave exactly as `hard_stop`: clear the lines, pulse `aborted`, return to IDLE.
- `IO_SEQ_TIMEOUT_EN` not defined: no counter; RUN waits indefinitely and `TIMEOUT_CYCLES` is unused.

## Test plan
- Single step: write step0 with every channel delay=2, duration=3 (model lines included); `num_steps`=1, `repeat_count`=1, start. Expect `line_go` high in cycle 3, all complete, `done` pulse, `busy` low.
- Multi-step: 3 steps with differing durations, `repeat_count`=2. Expect `cur_step` sequence 0,1,2,0,1,2, `cur_pass` 0 to 1, one `done` pulse, a 3-cycle gap between steps.
- Hard stop: `hard_stop` pulsed mid-RUN of step 1. Expect next cycle `line_go`=0 and `line_clr`=1, one `aborted` pulse, IDLE; a subsequent start runs normally.
- Config lockout: `cfg_we` while `busy` leaves the table unchanged, read back on the next run. `num_steps`=0 gives an immediate `done`.
- Reset mid-run: `rst` low during RUN. Expect all outputs 0 next cycle; table contents preserved.
- With `IO_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=50, one line's `line_complete` held low. Expect `aborted` 50 cycles after entering RUN.
